bomb_place_ctrl: RTL
====================

Name: bomb_place_ctrl

Overview:
Upstream feeder for the bomb-map updater. Turns each player's debounced bomb button into a validated bomb-placement request (x, y, valid) and holds it until the next bomb tick consumes it. Rejects illegal placements and enforces a per-player cooldown measured in bomb ticks. Runs on the fast game clock; bomb_tick is a one-cycle strobe aligned with the bomb-map updater's sampling edge.

Parameters:
COOLDOWN_TICKS, 2, bomb ticks a player must wait after a placement is consumed; 0 means no cooldown.
CNT_W, 3, cooldown counter width; must hold COOLDOWN_TICKS.

Ports:
clk  in  1  game clock
rst  in  1  synchronous, active-high reset
bomb_tick  in  1  one-cycle strobe; bomb-map updater samples requests in this cycle
btnA_bomb, btnB_bomb  in  1 each  debounced bomb buttons, level
playerAx, playerAy, playerBx, playerBy  in  4 each  player grid coordinates
healthA, healthB  in  2 each  current health
game_state  in  2  0 = running; nonzero = game over
i_curBombMap_0, i_curBombMap_1  in  100 each  bomb-map planes; cell index 10*x+y
bombA_x, bombA_y, bombB_x, bombB_y  out  4 each  latched request coordinates
bombA_v, bombB_v  out  1 each  request valid
rejA, rejB  out  1 each  one-cycle pulse: press rejected
busyA, busyB  out  1 each  high when the player is not in IDLE

Behaviour:
- Reset (rst high at a clk edge): all outputs 0, both FSMs IDLE, counters 0, edge-detect registers 0.
- Press = rising edge of btnX_bomb (current 1, previous-cycle sample 0). Holding the button produces only one press.
- Per-player FSM states: IDLE, PENDING, COOLDOWN.
- A press is accepted in IDLE only if all of these hold:
  - game_state == 0
  - health != 0
  - x and y are each in 1..8
  - cell 10*x+y is empty in both map planes
  - no collision with the other player (see below)
- Accepted press in cycle N: in cycle N+1, state = PENDING, bombX_v = 1, bombX_x/y = coordinates sampled in cycle N.
- Any other press: rejX = 1 in cycle N+1, state unchanged. This includes presses in PENDING or COOLDOWN.
- PENDING:
  - v and coordinates stay stable until a cycle with bomb_tick = 1.
  - v stays high during that tick cycle. In the next cycle v = 0 and the state moves on.
  - Next state: if COOLDOWN_TICKS = 0, go to IDLE. Otherwise go to COOLDOWN with cnt = COOLDOWN_TICKS.
  - A bomb_tick in the same cycle as the press is not consumed. The first tick that can consume the request is the first one seen while in PENDING.
- COOLDOWN:
  - cnt decrements on each bomb_tick.
  - A tick seen with cnt == 1 goes to IDLE next cycle.
  - A press is accepted again from the first IDLE cycle.
- Abort: if game_state != 0 or health == 0 while in PENDING or COOLDOWN, go to IDLE next cycle with v = 0 and cnt = 0. No request is issued.
- Collision rules, evaluated on the press cycle:
  - Both players press the same cell in the same cycle: A is accepted, B is rejected.
  - A press whose cell equals the other player's PENDING coordinates is rejected.
  - Presses for different cells in the same cycle are both accepted independently.
- Arithmetic:
  - Cell index is 10*x+y, computed at 7 bits. It is only indexed after the 1..8 range check, so the max index is 88.
  - Counters never underflow.
- Reset mid-PENDING: v drops the cycle after rst and no request leaks.
- bombX_x/y hold their last value when v = 0 (don't-care to the consumer).

Test Plan:
- Reset, A at (3,4), maps empty, press A -> one cycle later bombA_v=1, x=3, y=4. After first bomb_tick, v=0 next cycle and busyA=1. After 2 more ticks, busyA=0.
- Hold btnA_bomb high for 50 cycles -> exactly one request. A second press during COOLDOWN -> rejA pulse, no v.
- A and B both at (5,5), press in the same cycle -> bombA_v=1, bombB_v=0, rejB=1. B presses (5,5) while A is PENDING -> rejB=1.
- i_curBombMap_0 bit 34 set, A at (3,4) presses -> rejA=1. A at (0,4) or (9,2) -> rejA=1. healthA=0 -> rejA=1.
- A PENDING, then game_state=2 before any tick -> v=0 next cycle, IDLE, no request on the next tick. Same sequence with rst instead -> all outputs 0.
- COOLDOWN_TICKS=0 build: press, tick, press again the cycle after v drops -> accepted. A press coincident with bomb_tick -> v held until the following tick.

Source files
------------

// File: rtl/bomb_place_ctrl.sv
// Bomb-placement request generator: validates each player's bomb press, holds the
// request until a bomb tick consumes it, then enforces a per-player tick cooldown.
module bomb_place_ctrl #(
    parameter int COOLDOWN_TICKS = 2,
    parameter int CNT_W          = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bomb_tick,
    input  logic         btnA_bomb,
    input  logic         btnB_bomb,
    input  logic [3:0]   playerAx,
    input  logic [3:0]   playerAy,
    input  logic [3:0]   playerBx,
    input  logic [3:0]   playerBy,
    input  logic [1:0]   healthA,
    input  logic [1:0]   healthB,
    input  logic [1:0]   game_state,
    input  logic [99:0]  i_curBombMap_0,
    input  logic [99:0]  i_curBombMap_1,
    output logic [3:0]   bombA_x,
    output logic [3:0]   bombA_y,
    output logic [3:0]   bombB_x,
    output logic [3:0]   bombB_y,
    output logic         bombA_v,
    output logic         bombB_v,
    output logic         rejA,
    output logic         rejB,
    output logic         busyA,
    output logic         busyB
);

    typedef enum logic [1:0] {IDLE, PENDING, COOLDOWN} state_t;

    state_t           state [2];
    logic [CNT_W-1:0] cnt [2];
    logic [3:0]       px [2];
    logic [3:0]       py [2];
    logic [3:0]       bx [2];
    logic [3:0]       by [2];
    logic [1:0]       hp [2];
    logic [1:0]       btn, btnPrev, press, alive, legal, accept, reqValid, rejPulse;
    logic             sameCell;

    assign btn   = {btnB_bomb, btnA_bomb};
    assign px[0] = playerAx;
    assign py[0] = playerAy;
    assign px[1] = playerBx;
    assign py[1] = playerBy;
    assign hp[0] = healthA;
    assign hp[1] = healthB;

    // The map is only indexed once both coordinates are known to be 1..8 (index <= 88).
    function automatic logic placeOk(input logic [3:0] x, input logic [3:0] y);
        logic [6:0] idx;
        logic       ok;
        idx = '0;
        ok  = 1'b0;
        if (x >= 4'd1 && x <= 4'd8 && y >= 4'd1 && y <= 4'd8) begin
            idx = 7'(x) * 7'd10 + 7'(y);
            ok  = !(i_curBombMap_0[idx] || i_curBombMap_1[idx]);
        end
        return ok;
    endfunction

    always_comb begin
        press    = btn & ~btnPrev;
        sameCell = (px[0] == px[1]) && (py[0] == py[1]);
        alive[0] = (game_state == 2'd0) && (hp[0] != 2'd0);
        alive[1] = (game_state == 2'd0) && (hp[1] != 2'd0);
        legal[0] = alive[0] && placeOk(px[0], py[0]) &&
                   !(state[1] == PENDING && bx[1] == px[0] && by[1] == py[0]);
        legal[1] = alive[1] && placeOk(px[1], py[1]) &&
                   !(state[0] == PENDING && bx[0] == px[1] && by[0] == py[1]);
        // A wins a same-cycle race for the same cell.
        accept[0] = press[0] && state[0] == IDLE && legal[0];
        accept[1] = press[1] && state[1] == IDLE && legal[1] && !(accept[0] && sameCell);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btnPrev  <= '0;
            reqValid <= '0;
            rejPulse <= '0;
            for (int p = 0; p < 2; p++) begin
                state[p] <= IDLE;
                cnt[p]   <= '0;
                bx[p]    <= '0;
                by[p]    <= '0;
            end
        end else begin
            btnPrev  <= btn;
            rejPulse <= press & ~accept;
            for (int p = 0; p < 2; p++) begin
                case (state[p])
                    IDLE: begin
                        if (accept[p]) begin
                            state[p]    <= PENDING;
                            reqValid[p] <= 1'b1;
                            bx[p]       <= px[p];
                            by[p]       <= py[p];
                        end
                    end
                    PENDING: begin
                        if (!alive[p]) begin
                            state[p]    <= IDLE;
                            reqValid[p] <= 1'b0;
                            cnt[p]      <= '0;
                        end else if (bomb_tick) begin
                            reqValid[p] <= 1'b0;
                            if (COOLDOWN_TICKS == 0) begin
                                state[p] <= IDLE;
                            end else begin
                                state[p] <= COOLDOWN;
                                cnt[p]   <= CNT_W'(COOLDOWN_TICKS);
                            end
                        end
                    end
                    COOLDOWN: begin
                        if (!alive[p]) begin
                            state[p] <= IDLE;
                            cnt[p]   <= '0;
                        end else if (bomb_tick) begin
                            if (cnt[p] <= CNT_W'(1)) begin
                                state[p] <= IDLE;
                                cnt[p]   <= '0;
                            end else begin
                                cnt[p] <= cnt[p] - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state[p]    <= IDLE;
                        reqValid[p] <= 1'b0;
                        cnt[p]      <= '0;
                    end
                endcase
            end
        end
    end

    assign bombA_x = bx[0];
    assign bombA_y = by[0];
    assign bombB_x = bx[1];
    assign bombB_y = by[1];
    assign bombA_v = reqValid[0];
    assign bombB_v = reqValid[1];
    assign rejA    = rejPulse[0];
    assign rejB    = rejPulse[1];
    assign busyA   = (state[0] != IDLE);
    assign busyB   = (state[1] != IDLE);

endmodule
